// File: rtl/decode_pkg.sv
// Opcode/funct constants, ALU op encoding and the decoded control bundle shared
// by decode_stage and its scoreboard.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } aluOp_e;

    typedef struct packed {
        logic   hasDest;
        logic   memRead;
        logic   memWrite;
        logic   branch;
        logic   aluSrc;
        logic   illegal;
        aluOp_e aluOp;
        logic   useRs;
        logic   useRt;
        logic   destIsRd;
    } ctrl_t;

    // Anything not recognised decodes to illegal with every other field clear.
    function automatic ctrl_t decodeOp(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        c.aluOp = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.hasDest  = 1'b1;
                c.destIsRd = 1'b1;
                c.useRs    = 1'b1;
                c.useRt    = 1'b1;
                case (funct)
                    FN_ADD:  c.aluOp = ALU_ADD;
                    FN_SUB:  c.aluOp = ALU_SUB;
                    FN_AND:  c.aluOp = ALU_AND;
                    FN_OR:   c.aluOp = ALU_OR;
                    FN_SLT:  c.aluOp = ALU_SLT;
                    default: begin
                        c = '0;
                        c.aluOp   = ALU_ADD;
                        c.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                c.hasDest = 1'b1;
                c.aluSrc  = 1'b1;
                c.useRs   = 1'b1;
            end
            OP_LW: begin
                c.hasDest = 1'b1;
                c.aluSrc  = 1'b1;
                c.memRead = 1'b1;
                c.useRs   = 1'b1;
            end
            OP_SW: begin
                c.aluSrc   = 1'b1;
                c.memWrite = 1'b1;
                c.useRs    = 1'b1;
                c.useRt    = 1'b1;
            end
            OP_BEQ: begin
                c.aluOp  = ALU_SUB;
                c.branch = 1'b1;
                c.useRs  = 1'b1;
                c.useRt  = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits tracking in-flight writes; hazard detection only.
module reg_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          setEn,
    input  logic [AW-1:0] setReg,
    input  logic          clrEn,
    input  logic [AW-1:0] clrReg,
    input  logic [AW-1:0] src1Reg,
    input  logic [AW-1:0] src2Reg,
    input  logic [AW-1:0] destReg,
    output logic          src1Busy,
    output logic          src2Busy,
    output logic          destBusy
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNext;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        busyNext = busy;
        if (clrEn) busyNext[clrReg] = 1'b0;
        if (setEn) busyNext[setReg] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) busy <= '0;
        else         busy <= busyNext;
    end

    assign src1Busy = busy[src1Reg];
    assign src2Busy = busy[src2Reg];
    assign destBusy = busy[destReg];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with scoreboard interlock and ID/EX pipeline register.
// Optional WB_BYPASS_EN forwards same-cycle writeback data to operands.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          instrValid,
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] pcPlus4,
    output logic          instrReady,
    output logic [AW-1:0] readRegister1,
    output logic [AW-1:0] readRegister2,
    input  logic [DW-1:0] readData1,
    input  logic [DW-1:0] readData2,
    input  logic          wbRegWrite,
    input  logic [AW-1:0] wbWriteRegister,
    input  logic [DW-1:0] wbWriteData,
    output logic          exValid,
    input  logic          exReady,
    output logic [DW-1:0] exReadData1,
    output logic [DW-1:0] exReadData2,
    output logic [DW-1:0] exImm,
    output logic [DW-1:0] exPcPlus4,
    output logic [AW-1:0] exDestReg,
    output logic          exRegWrite,
    output logic          exMemRead,
    output logic          exMemWrite,
    output logic          exBranch,
    output logic          exAluSrc,
    output logic          exIllegal,
    output logic [3:0]    exAluOp
);

    ctrl_t         ctrl;
    logic [AW-1:0] rs, rt, rd, dest;
    logic          regWrite;
    logic          src1Busy, src2Busy, destBusy;
    logic          bypass1, bypass2;
    logic [DW-1:0] operand1, operand2, immExt;
    logic          hazard, accept;
    logic          unusedShamt;

    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign unusedShamt = ^instr[10:6];
    assign ctrl        = decodeOp(instr[31:26], instr[5:0]);
    assign dest        = ctrl.hasDest ? (ctrl.destIsRd ? rd : rt) : '0;
    assign regWrite    = (dest != '0);
    assign immExt      = {{(DW-16){instr[15]}}, instr[15:0]};

    assign readRegister1 = rs;
    assign readRegister2 = rt;

`ifdef WB_BYPASS_EN
    assign bypass1 = wbRegWrite && (wbWriteRegister == rs) && (rs != '0);
    assign bypass2 = wbRegWrite && (wbWriteRegister == rt) && (rt != '0);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    assign operand1 = bypass1 ? wbWriteData : readData1;
    assign operand2 = bypass2 ? wbWriteData : readData2;

    reg_scoreboard #(.AW(AW)) scoreboard (
        .clk      (clk),
        .resetN   (resetN),
        .setEn    (accept && regWrite),
        .setReg   (dest),
        .clrEn    (wbRegWrite),
        .clrReg   (wbWriteRegister),
        .src1Reg  (rs),
        .src2Reg  (rt),
        .destReg  (dest),
        .src1Busy (src1Busy),
        .src2Busy (src2Busy),
        .destBusy (destBusy)
    );

    // WAW is never bypassed: the pending write must retire before a new one issues.
    assign hazard = (ctrl.useRs && src1Busy && !bypass1)
                 || (ctrl.useRt && src2Busy && !bypass2)
                 || (regWrite && destBusy);

    assign instrReady = resetN && !hazard && (!exValid || exReady);
    assign accept     = instrValid && instrReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exValid     <= 1'b0;
            exReadData1 <= '0;
            exReadData2 <= '0;
            exImm       <= '0;
            exPcPlus4   <= '0;
            exDestReg   <= '0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            exMemWrite  <= 1'b0;
            exBranch    <= 1'b0;
            exAluSrc    <= 1'b0;
            exIllegal   <= 1'b0;
            exAluOp     <= '0;
        end else if (accept) begin
            exValid     <= 1'b1;
            exReadData1 <= operand1;
            exReadData2 <= operand2;
            exImm       <= immExt;
            exPcPlus4   <= pcPlus4;
            exDestReg   <= dest;
            exRegWrite  <= regWrite;
            exMemRead   <= ctrl.memRead;
            exMemWrite  <= ctrl.memWrite;
            exBranch    <= ctrl.branch;
            exAluSrc    <= ctrl.aluSrc;
            exIllegal   <= ctrl.illegal;
            exAluOp     <= ctrl.aluOp;
        end else if (exReady) begin
            exValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expectations follow WB_BYPASS_EN when defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        resetN;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        instrReady;
    logic [4:0]  readRegister1, readRegister2;
    logic [31:0] readData1, readData2;
    logic        wbRegWrite;
    logic [4:0]  wbWriteRegister;
    logic [31:0] wbWriteData;
    logic        exValid;
    logic        exReady;
    logic [31:0] exReadData1, exReadData2, exImm, exPcPlus4;
    logic [4:0]  exDestReg;
    logic        exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrc, exIllegal;
    logic [3:0]  exAluOp;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.AW(5), .DW(32)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .instrValid      (instrValid),
        .instr           (instr),
        .pcPlus4         (pcPlus4),
        .instrReady      (instrReady),
        .readRegister1   (readRegister1),
        .readRegister2   (readRegister2),
        .readData1       (readData1),
        .readData2       (readData2),
        .wbRegWrite      (wbRegWrite),
        .wbWriteRegister (wbWriteRegister),
        .wbWriteData     (wbWriteData),
        .exValid         (exValid),
        .exReady         (exReady),
        .exReadData1     (exReadData1),
        .exReadData2     (exReadData2),
        .exImm           (exImm),
        .exPcPlus4       (exPcPlus4),
        .exDestReg       (exDestReg),
        .exRegWrite      (exRegWrite),
        .exMemRead       (exMemRead),
        .exMemWrite      (exMemWrite),
        .exBranch        (exBranch),
        .exAluSrc        (exAluSrc),
        .exIllegal       (exIllegal),
        .exAluOp         (exAluOp)
    );

    // Register file model: combinational read, write at the clock edge.
    assign readData1 = regs[readRegister1];
    assign readData2 = regs[readRegister2];
    always @(posedge clk)
        if (wbRegWrite && wbWriteRegister != 5'd0) regs[wbWriteRegister] <= wbWriteData;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        instrValid      = 1'b0;
        wbRegWrite      = 1'b1;
        wbWriteRegister = r;
        wbWriteData     = d;
        tick();
        wbRegWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; instrValid = 1'b1; instr = 32'h20010005; pcPlus4 = 32'h104;
        exReady = 1'b1; wbRegWrite = 1'b0; wbWriteRegister = '0; wbWriteData = '0;
        #12;
        checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", instrReady); end
        checks++; if ({exValid, exRegWrite, exDestReg, exImm, exAluOp, exIllegal} !== '0) begin errors++; $display("FAIL reset_ex got v%b d%h i%h", exValid, exDestReg, exImm); end
        resetN = 1'b1;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", instrReady); end
        tick();
        checks++; if (exValid !== 1'b1 || exImm !== 32'd5 || exDestReg !== 5'd1 || exRegWrite !== 1'b1) begin errors++; $display("FAIL addi1 got v%b i%h d%0d w%b exp 1 5 1 1", exValid, exImm, exDestReg, exRegWrite); end
        checks++; if (exAluSrc !== 1'b1 || exAluOp !== 4'd0 || exPcPlus4 !== 32'h104) begin errors++; $display("FAIL addi1_ctl got s%b op%0d pc%h", exAluSrc, exAluOp, exPcPlus4); end
    endtask

    task automatic test_raw();
        instr = 32'h00211820; instrValid = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b exp 0", i, instrReady); end
            tick();
        end
        wbRegWrite = 1'b1; wbWriteRegister = 5'd1; wbWriteData = 32'd5;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b exp 1", instrReady); end
        tick();
        wbRegWrite = 1'b0; instrValid = 1'b0;
`else
        checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %b exp 0", instrReady); end
        tick();
        wbRegWrite = 1'b0;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL raw_after_wb got %b exp 1", instrReady); end
        tick();
        instrValid = 1'b0;
`endif
        checks++; if (exValid !== 1'b1 || exReadData1 !== 32'd5 || exReadData2 !== 32'd5 || exDestReg !== 5'd3) begin errors++; $display("FAIL raw_add got v%b a%h b%h d%0d exp 1 5 5 3", exValid, exReadData1, exReadData2, exDestReg); end
        writeback(5'd3, 32'd10);
    endtask

    task automatic test_sign_ext();
        instr = 32'h2002FFFF; instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        checks++; if (exImm !== 32'hFFFFFFFF || exDestReg !== 5'd2) begin errors++; $display("FAIL sign_ext got %h d%0d exp ffffffff 2", exImm, exDestReg); end
        writeback(5'd2, 32'hFFFFFFFF);
    endtask

    task automatic test_backpressure();
        instr = 32'h20061234; instrValid = 1'b1; exReady = 1'b1;
        tick();
        exReady = 1'b0; instr = 32'h20070009;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, instrReady); end
            tick();
            checks++; if (exValid !== 1'b1 || exImm !== 32'h1234 || exDestReg !== 5'd6) begin errors++; $display("FAIL bp_hold%0d got v%b i%h d%0d exp 1 1234 6", i, exValid, exImm, exDestReg); end
        end
        exReady = 1'b1;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", instrReady); end
        tick();
        instrValid = 1'b0;
        checks++; if (exImm !== 32'd9 || exDestReg !== 5'd7) begin errors++; $display("FAIL bp_next got i%h d%0d exp 9 7", exImm, exDestReg); end
        tick();
        checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", exValid); end
        writeback(5'd6, 32'h1234);
        writeback(5'd7, 32'd9);
    endtask

    task automatic test_reg_zero();
        instr = 32'h20000007; instrValid = 1'b1;
        tick();
        checks++; if (exRegWrite !== 1'b0 || exDestReg !== 5'd0 || exImm !== 32'd7) begin errors++; $display("FAIL r0_addi got w%b d%0d i%h exp 0 0 7", exRegWrite, exDestReg, exImm); end
        instr = 32'h00002020;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL r0_nostall got %b exp 1", instrReady); end
        tick();
        instrValid = 1'b0;
        checks++; if (exReadData1 !== 32'd0 || exDestReg !== 5'd4 || exRegWrite !== 1'b1) begin errors++; $display("FAIL r0_add got a%h d%0d exp 0 4", exReadData1, exDestReg); end
        writeback(5'd4, 32'd0);
    endtask

    task automatic test_controls();
        instrValid = 1'b1;
        instr = 32'hFC000000;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", instrReady); end
        tick();
        checks++; if ({exIllegal, exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrc, exAluOp, exDestReg} !== {1'b1, 14'd0}) begin errors++; $display("FAIL illegal_op got il%b w%b r%b m%b b%b s%b op%0d d%0d", exIllegal, exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrc, exAluOp, exDestReg); end
        instr = 32'h00000021;
        tick();
        checks++; if (exIllegal !== 1'b1 || exRegWrite !== 1'b0) begin errors++; $display("FAIL illegal_funct got il%b w%b exp 1 0", exIllegal, exRegWrite); end
        instr = 32'h8C080004;
        tick();
        checks++; if ({exMemRead, exMemWrite, exAluSrc, exRegWrite, exDestReg, exIllegal} !== {4'b1011, 5'd8, 1'b0}) begin errors++; $display("FAIL lw got r%b m%b s%b w%b d%0d", exMemRead, exMemWrite, exAluSrc, exRegWrite, exDestReg); end
        instr = 32'hAC090008;
        tick();
        checks++; if ({exMemRead, exMemWrite, exAluSrc, exRegWrite, exDestReg} !== {4'b0110, 5'd0}) begin errors++; $display("FAIL sw got r%b m%b s%b w%b d%0d", exMemRead, exMemWrite, exAluSrc, exRegWrite, exDestReg); end
        instr = 32'h1000FFFE;
        tick();
        checks++; if (exBranch !== 1'b1 || exAluOp !== 4'd1 || exImm !== 32'hFFFFFFFE || exRegWrite !== 1'b0) begin errors++; $display("FAIL beq got b%b op%0d i%h w%b", exBranch, exAluOp, exImm, exRegWrite); end
        instr = 32'h0000502A;
        tick();
        instrValid = 1'b0;
        checks++; if (exAluOp !== 4'd4 || exDestReg !== 5'd10 || exAluSrc !== 1'b0) begin errors++; $display("FAIL slt got op%0d d%0d s%b exp 4 10 0", exAluOp, exDestReg, exAluSrc); end
        writeback(5'd8, 32'd0);
        writeback(5'd10, 32'd0);
    endtask

    task automatic test_waw();
        instr = 32'h20050001; instrValid = 1'b1;
        tick();
        instr = 32'h20050002;
        #1;
        checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", instrReady); end
        tick();
        checks++; if (instrReady !== 1'b0) begin errors++; $display("FAIL waw_stall2 got %b exp 0", instrReady); end
        wbRegWrite = 1'b1; wbWriteRegister = 5'd5; wbWriteData = 32'd1;
        tick();
        wbRegWrite = 1'b0;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL waw_release got %b exp 1", instrReady); end
        tick();
        instrValid = 1'b0;
        checks++; if (exImm !== 32'd2 || exDestReg !== 5'd5) begin errors++; $display("FAIL waw_second got i%h d%0d exp 2 5", exImm, exDestReg); end
        writeback(5'd5, 32'd2);
    endtask

    task automatic test_mid_reset();
        instr = 32'h200B0003; instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        resetN = 1'b0;
        #1;
        checks++; if (exValid !== 1'b0 || exImm !== 32'd0 || exDestReg !== 5'd0) begin errors++; $display("FAIL midreset_ex got v%b i%h d%0d", exValid, exImm, exDestReg); end
        tick();
        resetN = 1'b1;
        instr = 32'h016B6020; instrValid = 1'b1;
        #1;
        checks++; if (instrReady !== 1'b1) begin errors++; $display("FAIL midreset_sb got %b exp 1", instrReady); end
        tick();
        instrValid = 1'b0;
        checks++; if (exValid !== 1'b1 || exDestReg !== 5'd12) begin errors++; $display("FAIL midreset_add got v%b d%0d exp 1 12", exValid, exDestReg); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        test_reset();
        test_raw();
        test_sign_ext();
        test_backpressure();
        test_reg_zero();
        test_controls();
        test_waw();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage for the pipelined microprocessor. Accepts fetched instructions over a valid/ready handshake and drives the register file read addresses. It sign-extends immediates, generates control, and interlocks on pending writes with a per-register scoreboard. Results are registered into the ID/EX pipeline register, which feeds the execute stage.

## Interface
- `AW`, 5: register address width (32 registers)
- `DW`, 32: data/instruction width
- `clk` in 1: clock; all state updates on rising edge
- `resetN` in 1: asynchronous, active-low reset
- `instrValid` in 1: fetch presents an instruction
- `instr` in DW: instruction word
- `pcPlus4` in DW: PC of instruction + 4
- `instrReady` out 1: decode accepts this cycle
- `readRegister1` / `readRegister2` out AW: register file read addresses (combinational from `instr` rs/rt)
- `readData1` / `readData2` in DW: register file read data (combinational)
- `wbRegWrite` in 1: writeback writes the register file this cycle
- `wbWriteRegister` in AW: writeback destination
- `wbWriteData` in DW: writeback data
- `exValid` out 1: ID/EX register holds an instruction
- `exReady` in 1: execute consumes ID/EX this cycle
- `exReadData1`, `exReadData2`, `exImm`, `exPcPlus4` out DW: operands, sign-extended imm[15:0], PC+4
- `exDestReg` out AW: destination register
- `exRegWrite`, `exMemRead`, `exMemWrite`, `exBranch`, `exAluSrc`, `exIllegal` out 1 each: control
- `exAluOp` out 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT

## Operation
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
- Decoded instructions:
  - R-type (op 0x00), funct 0x20/0x22/0x24/0x25/0x2A → ADD/SUB/AND/OR/SLT. dest = rd, sources rs and rt.
  - ADDI 0x08: ADD, aluSrc = 1, dest = rt, source rs.
  - LW 0x23: ADD, aluSrc = 1, memRead, dest = rt, source rs.
  - SW 0x2B: ADD, aluSrc = 1, memWrite, no dest, sources rs and rt.
  - BEQ 0x04: SUB, branch, no dest, sources rs and rt.
- Any other opcode/funct: exIllegal = 1, all other controls 0, no sources, no dest.
- A destination of register 0 gives exRegWrite = 0.
- Scoreboard: 32 busy bits.
  - On accept of an instruction with exRegWrite = 1, busy[dest] is set.
  - wbRegWrite clears busy[wbWriteRegister].
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is always 0.
- Hazard: any used source is busy, or dest is busy (WAW).
- instrReady = !hazard && (!exValid || exReady).
- Accept = instrValid && instrReady. On accept, ID/EX loads and exValid = 1.
- When exReady is 1 without an accept, exValid → 0.
- ID/EX is held stable while exValid && !exReady.

## Timing
- Reset: exValid = 0, all ex* outputs 0, all busy bits 0.
- instrReady is combinational; it is 0 while resetN is low.
- Latency: 1 cycle from accept to exValid.
- Throughput: 1 instruction/cycle when hazard-free and exReady = 1.
- Reset asserted mid-operation discards the ID/EX contents and the scoreboard immediately. No writeback is tracked across reset.
- A source that is busy stalls until writeback clears it. Exact cycle depends on the `WB_BYPASS_EN` setting (see Configuration).

## Configuration
- `WB_BYPASS_EN` defined:
  - A busy source whose writeback occurs in the same cycle is not a hazard.
  - Operand muxes select `wbWriteData` when wbRegWrite, wbWriteRegister == source, and source != 0.
  - Result: zero stall cycles after writeback.
- `WB_BYPASS_EN` undefined:
  - The busy-bit clear takes effect only after the edge.
  - Decode stalls through the writeback cycle and accepts the following cycle, reading the written value from the register file.
  - Result: one extra stall cycle per RAW hazard.

## Structure
- Package `decode_pkg`: opcode and funct constants, ALU op encoding, and a control-bundle struct typedef.
- Sub-module `reg_scoreboard`: 32 busy bits with set/clear ports and two source-check plus one dest-check outputs. It is hazard-only and holds no data.
- `decode_stage` contains the decoder, operand bypass mux, handshake logic, and the ID/EX register.

## Test plan
- Reset with instrValid = 1 → instrReady = 0 and all ex* outputs 0. After release, ADDI $1,$0,5 (0x20010005) gives exValid next cycle with exImm = 5, exDestReg = 1, exRegWrite = 1.
- Sign extension: ADDI $2,$0,-1 (0x2002FFFF) → exImm = 0xFFFFFFFF.
- RAW: ADDI $1 accepted, then ADD $3,$1,$1 presented → instrReady = 0 until wbRegWrite on reg 1 with data 5.
  - With `WB_BYPASS_EN`: accepted in that cycle, exReadData1 = exReadData2 = 5.
  - Without it: accepted one cycle later.
- Backpressure: exReady = 0 for 3 cycles → ID/EX held unchanged and instrReady = 0. Then exReady = 1 → next instruction accepted that cycle.
- Register 0: ADDI $0,$0,7 → exRegWrite = 0, no busy bit set. An immediately following ADD $4,$0,$0 is accepted without stall and exReadData1 = 0.
- Illegal instruction 0xFC000000 → exIllegal = 1 with all other controls 0, no stall. WAW: two back-to-back writes to $5 → the second stalls until writeback of $5.
